code_lock_ctrl: RTL and testbench

Four-digit code-lock controller that turns two push-button inputs into the 4-bit display code consumed by the seven-segment driver. It synchronises and edge-detects the buttons, collects four BCD digits, and compares them against a fixed secret. It then shows Correct / Error, and enforces a lockout after repeated failures. It sits directly upstream of the seven-segment driver; `disp_value` wires straight to its `value` input.

---
 rtl/code_lock_ctrl_pkg.sv | 30 +++
 rtl/code_lock_ctrl_btn_sync_edge.sv | 33 +++
 rtl/code_lock_ctrl.sv | 171 +++++++++++++++++
 tb/tb_code_lock_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_lock_ctrl_pkg.sv
// Shared display codes, state encoding and counter-sizing helpers for the code lock.
// Also consumed by the seven-segment driver so both ends agree on the symbol codes.
package code_lock_ctrl_pkg;

    localparam logic [3:0] DISP_CORRECT = 4'd10;
    localparam logic [3:0] DISP_ERROR   = 4'd11;
    localparam logic [3:0] DISP_OFF     = 4'd12;
    localparam logic [3:0] DISP_PROMPT  = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENTRY    = 3'd1,
        ST_CHECK    = 3'd2,
        ST_SHOW_OK  = 3'd3,
        ST_SHOW_ERR = 3'd4,
        ST_LOCKOUT  = 3'd5
    } state_t;

    function automatic logic [23:0] max3(input logic [23:0] a, input logic [23:0] b,
                                         input logic [23:0] c);
        logic [23:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int cnt_width(input logic [23:0] v);
        return (v > 24'd1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/code_lock_ctrl_btn_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector; one-cycle o_pulse, 2 clocks after the input rises.
// No backpressure: a press is reported once, and a button already high at reset release is never reported.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic       r_s1;
    logic       r_s2;
    logic       r_prev;
    logic [1:0] r_fill;

    // Until the synchroniser holds real samples, the previous level is treated as
    // pressed, so a button held through reset must be released before it counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b1;
            r_fill <= 2'b00;
        end else begin
            r_s1   <= i_btn;
            r_s2   <= r_s1;
            r_prev <= r_s2 | ~r_fill[1];
            r_fill <= {r_fill[0], 1'b1};
        end
    end

    assign o_pulse = r_s2 & ~r_prev;

endmodule

// File: rtl/code_lock_ctrl.sv
// Four-digit code lock: conditioned buttons drive entry, check, result display and failure lockout.
// Buttons act 2 clocks after they rise; presses during check/result/lockout are dropped, not queued.
module code_lock_ctrl
    import code_lock_ctrl_pkg::*;
#(
    parameter logic [15:0] SECRET         = 16'h1234,
    parameter logic [2:0]  MAX_FAILS      = 3'd3,
    parameter logic [23:0] RESULT_CYCLES  = 24'd10_000_000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd16_000_000,
    parameter logic [23:0] LOCKOUT_CYCLES = 24'd16_000_000,
    parameter logic [23:0] BLINK_CYCLES   = 24'd2_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_inc,
    input  logic       btn_ok,
    output logic [3:0] disp_value,
    output logic       unlocked,
    output logic [1:0] digit_idx
);

    localparam int CW = cnt_width(max3(RESULT_CYCLES, TIMEOUT_CYCLES, LOCKOUT_CYCLES));
    localparam int BW = cnt_width(BLINK_CYCLES);

    // Counters load N-1 on state entry so the state lasts exactly N cycles.
    localparam logic [CW-1:0] RESULT_LD  = CW'(RESULT_CYCLES - 24'd1);
    localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYCLES - 24'd1);
    localparam logic [CW-1:0] LOCKOUT_LD = CW'(LOCKOUT_CYCLES - 24'd1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [BW-1:0] BLINK_LD   = BW'(BLINK_CYCLES - 24'd1);
    localparam logic [BW-1:0] BLK_ONE    = BW'(1);

    logic          w_inc_p;
    logic          w_ok_p;
    logic          w_cnt_zero;
    logic [3:0]    w_disp;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_off;
    logic [3:0]    r_digit;
    logic [1:0]    r_idx;
    logic [15:0]   r_entry;
    logic [2:0]    r_fails;

    btn_sync_edge u_sync_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_inc),
        .o_pulse (w_inc_p)
    );

    btn_sync_edge u_sync_ok (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_ok),
        .o_pulse (w_ok_p)
    );

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
            r_digit     <= 4'd0;
            r_idx       <= 2'd0;
            r_entry     <= 16'd0;
            r_fails     <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ok_p) begin
                        r_state <= ST_ENTRY;
                        r_digit <= 4'd0;
                        r_idx   <= 2'd0;
                        r_entry <= 16'd0;
                        r_cnt   <= TIMEOUT_LD;
                    end
                end
                ST_ENTRY: begin
                    // ok takes priority over a coincident inc
                    if (w_ok_p) begin
                        r_entry <= {r_entry[11:0], r_digit};
                        r_digit <= 4'd0;
                        r_cnt   <= TIMEOUT_LD;
                        if (r_idx == 2'd3) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end else if (w_inc_p) begin
                        r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
                        r_cnt   <= TIMEOUT_LD;
                    end else if (w_cnt_zero) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_CHECK: begin
                    r_cnt <= RESULT_LD;
                    if (r_entry == SECRET) begin
                        r_state <= ST_SHOW_OK;
                        r_fails <= 3'd0;
                    end else begin
                        r_state <= ST_SHOW_ERR;
                        if (r_fails < MAX_FAILS) begin
                            r_fails <= r_fails + 3'd1;
                        end
                    end
                end
                ST_SHOW_OK: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_SHOW_ERR: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end else if (r_fails == MAX_FAILS) begin
                        r_state     <= ST_LOCKOUT;
                        r_cnt       <= LOCKOUT_LD;
                        r_blink_cnt <= BLINK_LD;
                        r_blink_off <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOCKOUT: begin
                    if (r_blink_cnt == '0) begin
                        r_blink_cnt <= BLINK_LD;
                        r_blink_off <= ~r_blink_off;
                    end else begin
                        r_blink_cnt <= r_blink_cnt - BLK_ONE;
                    end
                    if (w_cnt_zero) begin
                        r_state <= ST_IDLE;
                        r_fails <= 3'd0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_disp = DISP_PROMPT;
        case (r_state)
            ST_IDLE:     w_disp = DISP_PROMPT;
            ST_ENTRY:    w_disp = r_digit;
            ST_CHECK:    w_disp = DISP_OFF;
            ST_SHOW_OK:  w_disp = DISP_CORRECT;
            ST_SHOW_ERR: w_disp = DISP_ERROR;
            ST_LOCKOUT:  w_disp = r_blink_off ? DISP_OFF : DISP_ERROR;
            default:     w_disp = DISP_PROMPT;
        endcase
    end

    assign disp_value = w_disp;
    assign unlocked   = (r_state == ST_SHOW_OK);
    assign digit_idx  = r_idx;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Scoreboarded bench for code_lock_ctrl: a behavioural model queues expected display runs,
// a negedge monitor compresses DUT outputs into runs and compares them.
module tb_code_lock_ctrl;

    localparam int R_CYC = 8, T_CYC = 20, L_CYC = 16, B_CYC = 4, MAXF = 3, SECRET_DEC = 1234;
    localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_OK = 3, M_ERR = 4, M_LOCK = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_inc;
    logic       btn_ok;
    logic [3:0] disp_value;
    logic       unlocked;
    logic [1:0] digit_idx;

    always #5 clk = ~clk;

    code_lock_ctrl #(
        .SECRET         (16'h1234),
        .MAX_FAILS      (3'd3),
        .RESULT_CYCLES  (24'd8),
        .TIMEOUT_CYCLES (24'd20),
        .LOCKOUT_CYCLES (24'd16),
        .BLINK_CYCLES   (24'd4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_inc    (btn_inc),
        .btn_ok     (btn_ok),
        .disp_value (disp_value),
        .unlocked   (unlocked),
        .digit_idx  (digit_idx)
    );

    typedef struct packed {
        logic [3:0] disp;
        logic       unl;
        logic [1:0] idx;
    } obs_t;

    typedef struct {
        obs_t o;
        int   len;
    } run_t;

    run_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   stop = 0;
    bit   mon_done = 0;

    // Reference model state (high-level: mode, digits typed so far, ages in cycles)
    int   m_mode, m_digit, m_idx, m_fails, m_age, m_quiet;
    int   m_digits[$];
    bit   h_inc[$];
    bit   h_ok[$];
    obs_t m_cur;
    int   m_len = 0;
    bit   m_have = 0;

    task automatic model_reset();
        m_mode = M_IDLE; m_digit = 0; m_idx = 0; m_fails = 0; m_age = 0; m_quiet = 0;
        m_digits.delete();
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.unl = (m_mode == M_OK);
        o.idx = 2'(m_idx);
        case (m_mode)
            M_ENTRY: o.disp = 4'(m_digit);
            M_CHECK: o.disp = 4'd12;
            M_OK:    o.disp = 4'd10;
            M_ERR:   o.disp = 4'd11;
            M_LOCK:  o.disp = (((m_age / B_CYC) % 2) == 1) ? 4'd12 : 4'd11;
            default: o.disp = 4'd13;
        endcase
        return o;
    endfunction

    // Advance the model by one clock edge; history before reset release counts as "pressed".
    task automatic model_step(input bit in_rst);
        bit   pi, po;
        int   code;
        obs_t o;
        if (in_rst) begin
            h_inc.push_back(1'b1); h_ok.push_back(1'b1);
        end else begin
            h_inc.push_back(btn_inc); h_ok.push_back(btn_ok);
        end
        while (h_inc.size() > 4) void'(h_inc.pop_front());
        while (h_ok.size() > 4) void'(h_ok.pop_front());
        pi = h_inc[1] & ~h_inc[0];
        po = h_ok[1] & ~h_ok[0];
        if (in_rst) begin
            model_reset();
        end else begin
            case (m_mode)
                M_IDLE: if (po) begin
                    m_mode = M_ENTRY; m_digit = 0; m_idx = 0; m_quiet = 0; m_digits.delete();
                end
                M_ENTRY: begin
                    if (po) begin
                        m_digits.push_back(m_digit);
                        m_digit = 0; m_quiet = 0;
                        if (m_digits.size() == 4) m_mode = M_CHECK;
                        else m_idx = m_digits.size();
                    end else if (pi) begin
                        m_digit = (m_digit + 1) % 10; m_quiet = 0;
                    end else begin
                        m_quiet++;
                        if (m_quiet == T_CYC) m_mode = M_IDLE;
                    end
                end
                M_CHECK: begin
                    code = m_digits[0] * 1000 + m_digits[1] * 100 + m_digits[2] * 10 + m_digits[3];
                    m_age = 0;
                    if (code == SECRET_DEC) begin
                        m_mode = M_OK; m_fails = 0;
                    end else begin
                        m_mode = M_ERR;
                        if (m_fails < MAXF) m_fails++;
                    end
                end
                M_OK: begin
                    m_age++;
                    if (m_age == R_CYC) m_mode = M_IDLE;
                end
                M_ERR: begin
                    m_age++;
                    if (m_age == R_CYC) begin
                        if (m_fails == MAXF) begin m_mode = M_LOCK; m_age = 0; end
                        else m_mode = M_IDLE;
                    end
                end
                M_LOCK: begin
                    m_age++;
                    if (m_age == L_CYC) begin m_fails = 0; m_mode = M_IDLE; end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        o = model_obs();
        if (!m_have) begin
            m_cur = o; m_len = 1; m_have = 1;
        end else if (o == m_cur) begin
            m_len++;
        end else begin
            exp_q.push_back('{o: m_cur, len: m_len});
            m_cur = o; m_len = 1;
        end
    endtask

    task automatic tick(input bit do_assert = 1'b0, input bit do_release = 1'b0);
        bit in_rst;
        @(posedge clk);
        #1;
        if (do_assert) rst_n = 1'b0;
        in_rst = (rst_n == 1'b0);
        model_step(in_rst);
        if (do_release) rst_n = 1'b1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic press(input bit is_ok, input bit both);
        int hi, lo;
        hi = $urandom_range(1, 3);
        lo = $urandom_range(1, 3);
        if (both) begin btn_inc = 1'b1; btn_ok = 1'b1; end
        else if (is_ok) btn_ok = 1'b1;
        else btn_inc = 1'b1;
        repeat (hi) tick();
        btn_inc = 1'b0; btn_ok = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic enter_digit(input int n);
        repeat (n) press(1'b0, 1'b0);
        press(1'b1, 1'b0);
    endtask

    task automatic wait_mode(input int mode, input string name);
        int k;
        k = 0;
        while (m_mode != mode && k < 200) begin tick(); k++; end
        if (m_mode != mode) begin
            total++; bad++;
            $display("FAIL %s: model mode %0d never reached %0d", name, m_mode, mode);
        end
    endtask

    task automatic enter_code(input int d0, input int d1, input int d2, input int d3);
        wait_mode(M_IDLE, "pre_code_idle");
        press(1'b1, 1'b0);
        enter_digit(d0); enter_digit(d1); enter_digit(d2); enter_digit(d3);
    endtask

    task automatic reset_pulse();
        tick(1'b1, 1'b0);
        #1;
        check("rst_async_disp", disp_value, 13);
        check("rst_async_unl", unlocked, 0);
        check("rst_async_idx", digit_idx, 0);
        tick();
        tick(1'b0, 1'b1);
    endtask

    task automatic close_run(input obs_t got, input int glen, input string name);
        run_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: DUT run disp=%0d unl=%0d idx=%0d len=%0d with nothing expected",
                     name, got.disp, got.unl, got.idx, glen);
        end else begin
            e = exp_q.pop_front();
            if (e.o !== got || e.len != glen) begin
                bad++;
                $display("FAIL %s: got disp=%0d unl=%0d idx=%0d len=%0d, expected disp=%0d unl=%0d idx=%0d len=%0d",
                         name, got.disp, got.unl, got.idx, glen, e.o.disp, e.o.unl, e.o.idx, e.len);
            end
        end
    endtask

    // Monitor: every change of the observable outputs closes a run and is scored.
    initial begin : monitor
        obs_t cur, s;
        int   len;
        bit   have;
        have = 0; len = 0;
        @(posedge clk);
        while (!mon_done) begin
            @(negedge clk);
            s.disp = disp_value; s.unl = unlocked; s.idx = digit_idx;
            if (!have) begin
                cur = s; len = 1; have = 1;
            end else if (s === cur) begin
                len++;
            end else begin
                close_run(cur, len, "run");
                cur = s; len = 1;
            end
            if (stop) begin
                check("leftover_runs", exp_q.size(), 0);
                exp_q.push_back('{o: m_cur, len: m_len});
                close_run(cur, len, "final_run");
                mon_done = 1;
            end
        end
    end

    initial begin : stimulus
        int r;
        model_reset();
        for (int i = 0; i < 4; i++) begin h_inc.push_back(1'b1); h_ok.push_back(1'b1); end
        rst_n = 1'b0; btn_inc = 1'b1; btn_ok = 1'b1;

        // 1: release reset with both buttons held
        repeat (3) tick();
        tick(1'b0, 1'b1);
        repeat (5) tick();
        check("held_through_reset_disp", disp_value, 13);
        check("held_through_reset_unl", unlocked, 0);
        btn_inc = 1'b0; btn_ok = 1'b0;
        repeat (4) tick();
        check("after_release_disp", disp_value, 13);

        // 2: correct code
        enter_code(1, 2, 3, 4);
        wait_mode(M_OK, "reach_ok");
        check("ok_unlocked", unlocked, 1);
        wait_mode(M_IDLE, "ok_to_idle");

        // 3: wrap and ok/inc collision
        press(1'b1, 1'b0);
        repeat (11) press(1'b0, 1'b0);
        tick(); tick();
        check("wrap_digit", disp_value, 1);
        press(1'b0, 1'b1);
        tick(); tick();
        check("collision_idx", digit_idx, 1);
        check("collision_digit", disp_value, 0);
        enter_digit(2); enter_digit(3); enter_digit(4);
        wait_mode(M_IDLE, "collision_done");

        // 4: three wrong codes -> lockout, then a normal attempt
        repeat (3) begin
            enter_code(0, 0, 0, 0);
            wait_mode(M_ERR, "wrong_err");
        end
        wait_mode(M_LOCK, "reach_lockout");
        wait_mode(M_IDLE, "lockout_done");
        enter_code(1, 2, 3, 4);
        wait_mode(M_IDLE, "after_lockout_ok");

        // 5: timeout keeps fail count; reset during error display clears it
        enter_code(9, 9, 9, 9);
        wait_mode(M_IDLE, "t5_first_wrong");
        press(1'b1, 1'b0);
        enter_digit(5); enter_digit(6);
        repeat (25) tick();
        check("timeout_disp", disp_value, 13);
        enter_code(7, 7, 7, 7);
        wait_mode(M_IDLE, "t5_second_wrong");
        enter_code(8, 8, 8, 8);
        wait_mode(M_ERR, "t5_third_err");
        tick(); tick();
        reset_pulse();
        enter_code(0, 0, 0, 1);
        wait_mode(M_IDLE, "t5_after_reset");

        // Random phase
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 99);
            if (r < 40) press(1'b0, 1'b0);
            else if (r < 65) press(1'b1, 1'b0);
            else if (r < 72) press(1'b0, 1'b1);
            else if (r < 87) repeat ($urandom_range(1, 25)) tick();
            else if (r < 96) begin
                if ($urandom_range(0, 1) == 1) enter_code(1, 2, 3, 4);
                else enter_code($urandom_range(0, 9), $urandom_range(0, 9),
                                $urandom_range(0, 9), $urandom_range(0, 9));
            end else reset_pulse();
        end
        repeat (5) tick();

        stop = 1;
        repeat (5) @(posedge clk);
        if (!mon_done) begin
            total++; bad++;
            $display("FAIL monitor_done: monitor did not finish");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
